// File: rtl/fifo_pkg.sv
// Shared definitions for the banked single-port-RAM FIFO and its read-side drain.
package fifo_pkg;

  localparam int unsigned MAX_RD_LATENCY  = 2;
  localparam int unsigned FIFO_WORD_WIDTH = 8;

  typedef logic [FIFO_WORD_WIDTH-1:0] fifo_word_t;

  // Bits needed to hold the value n, i.e. ceil(log2(n+1)); never less than 1.
  function automatic int unsigned clog2_p1(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((n >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_pop_stream_skid_ring.sv
// Circular skid buffer with explicit pointer wrap and a one-cycle synchronous clear.
module skid_ring
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned CNT_WIDTH  = clog2_p1(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic [CNT_WIDTH-1:0]  occupancy_o
);

  localparam int unsigned            PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_WIDTH-1:0]   LAST_PTR  = PTR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_WIDTH-1:0]  head_q, head_d;
  logic [PTR_WIDTH-1:0]  tail_q, tail_d;
  logic [CNT_WIDTH-1:0]  occ_q, occ_d;
  logic                  wr_en;

  // Compare-and-clear so that non-power-of-two depths wrap at DEPTH.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  assign wr_en = push_i && !clear_i;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (clear_i) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (push_i) tail_d = ptr_inc(tail_q);
      if (pop_i)  head_d = ptr_inc(head_q);
      case ({push_i, pop_i})
        2'b10:   occ_d = occ_q + CNT_WIDTH'(1);
        2'b01:   occ_d = occ_q - CNT_WIDTH'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
    end else if (wr_en) begin
      mem_q[tail_q] <= push_data_i;
    end
  end

  assign head_data_o = mem_q[head_q];
  assign occupancy_o = occ_q;

endmodule

// File: rtl/fifo_pop_stream.sv
// Read-side drain engine: pops the FIFO, tracks in-flight reads, and streams the
// returned words out of a skid buffer with flush support.
module fifo_pop_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned SKID_DEPTH = RD_LATENCY + 1,
  parameter int unsigned CNT_WIDTH  = clog2_p1(SKID_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_ren,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  occupancy,
  output logic                  busy
);

  if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY || SKID_DEPTH < RD_LATENCY + 1)
  begin : g_bad_cfg
    $error("fifo_pop_stream: unsupported RD_LATENCY/SKID_DEPTH combination");
  end

  logic                  run_q;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [CNT_WIDTH-1:0]  discard_q, discard_d;
  logic [CNT_WIDTH-1:0]  inflight;
  logic [CNT_WIDTH:0]    committed;
  logic                  budget_ok;
  logic                  pop_out;
  logic                  ret_exit;
  logic                  ret_push;

  // Holds pops off until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) run_q <= 1'b0;
    else     run_q <= 1'b1;
  end

  assign pop_out   = m_valid && m_ready;
  assign inflight  = CNT_WIDTH'($countones(vld_q));
  assign committed = {1'b0, occupancy} + {1'b0, inflight};
  assign budget_ok = committed < (CNT_WIDTH + 1)'(SKID_DEPTH);
  assign fifo_ren  = run_q && !fifo_empty && !flush && (budget_ok || pop_out);

  if (RD_LATENCY > 1) begin : g_shift
    assign vld_d = {vld_q[RD_LATENCY-2:0], fifo_ren};
  end else begin : g_single
    assign vld_d = fifo_ren;
  end

  assign ret_exit = vld_q[RD_LATENCY-1];
  assign ret_push = ret_exit && (discard_q == '0);

  // On flush the counter takes every in-flight stage; the stage leaving on the
  // flush edge itself is absorbed by the ring clear, so it is retired at once.
  always_comb begin
    discard_d = discard_q;
    if (flush) begin
      discard_d = inflight - CNT_WIDTH'(ret_exit);
    end else if (ret_exit && (discard_q != '0)) begin
      discard_d = discard_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= '0;
      discard_q <= '0;
    end else begin
      vld_q     <= vld_d;
      discard_q <= discard_d;
    end
  end

  skid_ring #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (SKID_DEPTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_ring (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (flush),
    .push_i      (ret_push),
    .push_data_i (fifo_rdata),
    .pop_i       (pop_out),
    .head_data_o (m_data),
    .occupancy_o (occupancy)
  );

  assign m_valid = (occupancy != '0);
  assign busy    = (inflight != '0) || (occupancy != '0) || (discard_q != '0);

endmodule
